// File: rtl/rom_arb_pkg.sv
// Shared types for the program ROM read arbiter.
// Tag layout, port ids, read latency and counter helpers.
package rom_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_AUX = 1'b1;

  localparam int RD_LATENCY = 3;
  localparam int CNT_W      = 16;

  typedef struct packed {
    logic     valid;
    port_id_t owner;
  } rd_tag_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             en
  );
    logic [CNT_W-1:0] r;
    r = c;
    if (en && (c != '1)) r = c + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request arbiter with round-robin or fixed priority.
// Remembers the most recently granted port between cycles.
module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  port_id_t last_q;

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          // On contention the port not served last goes first
          if (fixed_prio || (last_q == PORT_AUX))
            gnt = 2'b01;
          else
            gnt = 2'b10;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= PORT_CPU;
    else if (|gnt)
      last_q <= gnt[1];
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares a registered-read program ROM between two read ports.
// ROM_ARB_STATS_EN adds grant and contention counters.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  output logic              GNT0,
  output logic              RVALID0,
  output logic [DATA_W-1:0] RDATA0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  output logic              GNT1,
  output logic              RVALID1,
  output logic [DATA_W-1:0] RDATA1,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [DATA_W-1:0] ROM_DATA
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  GRANT_CNT0,
  output logic [CNT_W-1:0]  GRANT_CNT1,
  output logic [CNT_W-1:0]  CONTENTION_CNT
`endif
);

  localparam int STAGES = RD_LATENCY - 1;

  logic [1:0] gnt;
  rd_tag_t    tag_d;
  rd_tag_t    tag_q [STAGES];
  rd_tag_t    rsp;
  logic       rsp0;
  logic       rsp1;

  rr_arb2 u_arb (
    .clk        (CLK),
    .rst_n      (RESETN),
    .req        ({REQ1, REQ0}),
    .fixed_prio (FIXED_PRIO),
    .gnt        (gnt)
  );

  assign GNT0 = gnt[0];
  assign GNT1 = gnt[1];

  always_comb begin
    tag_d       = '0;
    tag_d.valid = |gnt;
    tag_d.owner = gnt[1];
  end

  // Stage 0 lines up with the ROM address, the last stage with ROM data
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ROM_ADDR <= '0;
      for (int i = 0; i < STAGES; i++)
        tag_q[i] <= '0;
    end else begin
      if (|gnt)
        ROM_ADDR <= gnt[1] ? ADDR1 : ADDR0;
      tag_q[0] <= tag_d;
      for (int i = 1; i < STAGES; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign rsp  = tag_q[STAGES-1];
  assign rsp0 = rsp.valid && (rsp.owner == PORT_CPU);
  assign rsp1 = rsp.valid && (rsp.owner == PORT_AUX);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RDATA0  <= '0;
      RDATA1  <= '0;
    end else begin
      RVALID0 <= rsp0;
      RVALID1 <= rsp1;
      if (rsp0) RDATA0 <= ROM_DATA;
      if (rsp1) RDATA1 <= ROM_DATA;
    end
  end

`ifdef ROM_ARB_STATS_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      GRANT_CNT0     <= '0;
      GRANT_CNT1     <= '0;
      CONTENTION_CNT <= '0;
    end else begin
      GRANT_CNT0     <= sat_inc(GRANT_CNT0, gnt[0]);
      GRANT_CNT1     <= sat_inc(GRANT_CNT1, gnt[1]);
      CONTENTION_CNT <= sat_inc(CONTENTION_CNT, REQ0 && REQ1);
    end
  end
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter, round-robin and fixed priority.
// Both instances share stimulus; each has its own ROM model.
module tb_rom_read_arbiter;

  logic       CLK    = 1'b0;
  logic       RESETN = 1'b0;
  logic       REQ0   = 1'b0;
  logic       REQ1   = 1'b0;
  logic [7:0] ADDR0  = 8'h00;
  logic [7:0] ADDR1  = 8'h00;

  logic       gnt0_r, gnt1_r, rv0_r, rv1_r;
  logic [7:0] rd0_r, rd1_r, ra_r;
  logic [7:0] rdat_r = 8'h00;
  logic       gnt0_f, gnt1_f, rv0_f, rv1_f;
  logic [7:0] rd0_f, rd1_f, ra_f;
  logic [7:0] rdat_f = 8'h00;
`ifdef ROM_ARB_STATS_EN
  logic [15:0] gc0_r, gc1_r, cc_r, gc0_f, gc1_f, cc_f;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rom_read_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1'b0)) u_rr (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0(REQ0), .ADDR0(ADDR0), .GNT0(gnt0_r),
    .RVALID0(rv0_r), .RDATA0(rd0_r),
    .REQ1(REQ1), .ADDR1(ADDR1), .GNT1(gnt1_r),
    .RVALID1(rv1_r), .RDATA1(rd1_r),
    .ROM_ADDR(ra_r), .ROM_DATA(rdat_r)
`ifdef ROM_ARB_STATS_EN
    , .GRANT_CNT0(gc0_r), .GRANT_CNT1(gc1_r), .CONTENTION_CNT(cc_r)
`endif
  );

  rom_read_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1'b1)) u_fp (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0(REQ0), .ADDR0(ADDR0), .GNT0(gnt0_f),
    .RVALID0(rv0_f), .RDATA0(rd0_f),
    .REQ1(REQ1), .ADDR1(ADDR1), .GNT1(gnt1_f),
    .RVALID1(rv1_f), .RDATA1(rd1_f),
    .ROM_ADDR(ra_f), .ROM_DATA(rdat_f)
`ifdef ROM_ARB_STATS_EN
    , .GRANT_CNT0(gc0_f), .GRANT_CNT1(gc1_f), .CONTENTION_CNT(cc_f)
`endif
  );

  // ROM contents: addr ^ 0xB5, so ROM[0x10] = 0xA5
  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  always_ff @(posedge CLK) begin
    rdat_r <= rom_f(ra_r);
    rdat_f <= rom_f(ra_f);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r0, input logic [7:0] a0,
                     input logic r1, input logic [7:0] a1);
    @(posedge CLK);
    #1;
    REQ0  = r0;
    ADDR0 = a0;
    REQ1  = r1;
    ADDR1 = a1;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1;
    RESETN = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    REQ0   = 1'b0;
    REQ1   = 1'b0;
    @(negedge CLK);
  endtask

  logic [8:0] e_rg0, e_rg1, e_fg0, e_fg1;
  logic [8:0] e_rv0, e_rv1, e_fv0, e_fv1;
  logic [7:0] e_d;

  initial begin
    // reset state, GNT forced low with a request pending
    REQ0  = 1'b1;
    ADDR0 = 8'h10;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_gnt0_r", gnt0_r, 1'b0);
    check("rst_gnt0_f", gnt0_f, 1'b0);
    check("rst_romaddr", ra_r, 8'h00);
    check("rst_rv0", rv0_r, 1'b0);
    check("rst_rd0", rd0_r, 8'h00);
    check("rst_rv1_f", rv1_f, 1'b0);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    REQ0   = 1'b0;
    @(negedge CLK);

    // single port-0 read, 3-cycle latency
    cyc(1'b1, 8'h10, 1'b0, 8'h00);
    check("t1_gnt0", gnt0_r, 1'b1);
    check("t1_gnt1", gnt1_r, 1'b0);
    idle(1);
    check("t1_rv0_c1", rv0_r, 1'b0);
    idle(1);
    check("t1_rv0_c2", rv0_r, 1'b0);
    idle(1);
    check("t1_rv0_c3", rv0_r, 1'b1);
    check("t1_rd0_c3", rd0_r, 8'hA5);
    check("t1_rv1_c3", rv1_r, 1'b0);
    check("t1_rd0_f", rd0_f, 8'hA5);
    idle(1);
    check("t1_rv0_c4", rv0_r, 1'b0);
    check("t1_rd0_hold", rd0_r, 8'hA5);
    check("t1_romaddr_hold", ra_r, 8'h10);

    // port-1 read leaves the RR pointer on port 1
    cyc(1'b0, 8'h00, 1'b1, 8'h20);
    check("t2p_gnt1", gnt1_r, 1'b1);
    idle(3);
    check("t2p_rv1", rv1_r, 1'b1);
    check("t2p_rd1", rd1_r, 8'h95);
    check("t2p_rv0", rv0_r, 1'b0);
    idle(1);

    // contention for 4 cycles, then REQ0 drops with REQ1 still up
    e_rg0 = 9'b000000101;
    e_rg1 = 9'b000011010;
    e_fg0 = 9'b000001111;
    e_fg1 = 9'b000010000;
    e_rv0 = 9'b000101000;
    e_rv1 = 9'b011010000;
    e_fv0 = 9'b001111000;
    e_fv1 = 9'b010000000;
    for (int k = 0; k < 9; k++) begin
      cyc(k < 4, 8'h30, k < 5, 8'h31);
      check($sformatf("t2_rr_g0_%0d", k), gnt0_r, e_rg0[k]);
      check($sformatf("t2_rr_g1_%0d", k), gnt1_r, e_rg1[k]);
      check($sformatf("t2_fp_g0_%0d", k), gnt0_f, e_fg0[k]);
      check($sformatf("t2_fp_g1_%0d", k), gnt1_f, e_fg1[k]);
      check($sformatf("t2_rr_v0_%0d", k), rv0_r, e_rv0[k]);
      check($sformatf("t2_rr_v1_%0d", k), rv1_r, e_rv1[k]);
      check($sformatf("t2_fp_v0_%0d", k), rv0_f, e_fv0[k]);
      check($sformatf("t2_fp_v1_%0d", k), rv1_f, e_fv1[k]);
      if (e_rv0[k]) check($sformatf("t2_rr_d0_%0d", k), rd0_r, 8'h85);
      if (e_rv1[k]) check($sformatf("t2_rr_d1_%0d", k), rd1_r, 8'h84);
      if (e_fv0[k]) check($sformatf("t2_fp_d0_%0d", k), rd0_f, 8'h85);
      if (e_fv1[k]) check($sformatf("t2_fp_d1_%0d", k), rd1_f, 8'h84);
    end

    // back-to-back port-0 stream across the address wrap
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       cyc(1'b1, 8'hFE, 1'b0, 8'h00);
        1:       cyc(1'b1, 8'hFF, 1'b0, 8'h00);
        2:       cyc(1'b1, 8'h00, 1'b0, 8'h00);
        default: cyc(1'b0, 8'h00, 1'b0, 8'h00);
      endcase
      case (k)
        3:       e_d = 8'h4B;
        4:       e_d = 8'h4A;
        default: e_d = 8'hB5;
      endcase
      check($sformatf("t3_v0_%0d", k), rv0_r, (k >= 3) && (k <= 5));
      check($sformatf("t3_v1_%0d", k), rv1_r, 1'b0);
      check($sformatf("t3_fv0_%0d", k), rv0_f, (k >= 3) && (k <= 5));
      if ((k >= 3) && (k <= 5)) begin
        check($sformatf("t3_d0_%0d", k), rd0_r, e_d);
        check($sformatf("t3_fd0_%0d", k), rd0_f, e_d);
      end
    end
    check("t3_romaddr_hold", ra_r, 8'h00);

    // reset one cycle after a grant drops the read
    cyc(1'b1, 8'h40, 1'b0, 8'h00);
    check("t4_gnt0", gnt0_r, 1'b1);
    @(posedge CLK);
    #1;
    RESETN = 1'b0;
    @(negedge CLK);
    check("t4_rst_gnt0", gnt0_r, 1'b0);
    check("t4_rst_rv0", rv0_r, 1'b0);
    check("t4_rst_ra", ra_r, 8'h00);
    check("t4_rst_rd0", rd0_r, 8'h00);
    check("t4_rst_rd1", rd1_r, 8'h00);
    check("t4_rst_rd1_f", rd1_f, 8'h00);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    REQ0   = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check($sformatf("t4_norv_%0d", k), {rv0_r, rv1_r, rv0_f, rv1_f}, 4'b0);
    end
    cyc(1'b1, 8'h11, 1'b0, 8'h00);
    check("t4_post_gnt0", gnt0_r, 1'b1);
    idle(3);
    check("t4_post_rv0", rv0_r, 1'b1);
    check("t4_post_rd0", rd0_r, 8'hA4);

`ifdef ROM_ARB_STATS_EN
    pulse_reset();
    check("st_rst_gc0", gc0_r, 16'h0000);
    check("st_rst_cc", cc_r, 16'h0000);
    cyc(1'b1, 8'h01, 1'b0, 8'h00);
    cyc(1'b1, 8'h02, 1'b0, 8'h00);
    cyc(1'b1, 8'h03, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'h04);
    cyc(1'b1, 8'h05, 1'b1, 8'h06);
    cyc(1'b1, 8'h05, 1'b1, 8'h06);
    cyc(1'b1, 8'h07, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'h08);
    idle(1);
    check("st_gc0_r", gc0_r, 16'd5);
    check("st_gc1_r", gc1_r, 16'd3);
    check("st_cc_r", cc_r, 16'd2);
    check("st_gc0_f", gc0_f, 16'd6);
    check("st_gc1_f", gc1_f, 16'd2);
    check("st_cc_f", cc_f, 16'd2);
    for (int i = 0; i < 65540; i++) cyc(1'b1, 8'h00, 1'b0, 8'h00);
    idle(1);
    check("st_sat_gc0", gc0_r, 16'hFFFF);
    check("st_sat_gc1", gc1_r, 16'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
